// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write handshake between the CPU MMIO path and the UART TX FIFO
// Purpose: carries one character per accepted write into uart_tx_fifo.
// Signals:
//   wvalid  master->slave  write request
//   wdata   master->slave  character, bit 0 sent first
//   wready  slave->master  FIFO not full; write accepted when wvalid & wready
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 wvalid;
  logic [DATA_BITS-1:0] wdata;
  logic                 wready;

  modport master (output wvalid, output wdata, input wready);
  modport slave  (input wvalid, input wdata, output wready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format
// Purpose: queues characters in a circular FIFO and serialises them as
//   start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   wr       write handshake (slave modport: wvalid, wdata, wready)
//   level    words held in the FIFO, excluding the frame in flight
//   busy     frame in flight or FIFO non-empty
//   uart_tx  registered serial line, idle high
module uart_tx_fifo #(
  parameter int SYSTEM_CLK = 50_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               wr,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        uart_tx
);
  localparam int DIV = (SYSTEM_CLK + BAUDRATE / 2) / BAUDRATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(STOP_BITS * DIV);

  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] sh;
  logic                 p;
  logic [3:0]           bit_idx;
  logic [CW-1:0]        cnt;
  logic                 push;
  logic                 pop;
  logic                 p_next;

  assign wr.wready = (level != FULL_LVL);
  assign push      = wr.wvalid & wr.wready;
  // Pop only where a new frame can begin: from idle, or on the final stop-bit cycle.
  assign pop       = (|level) && ((state == IDLE) || (state == STOP && cnt == '0));
  assign busy      = (state != IDLE) || (|level);
  assign p_next    = p ^ sh[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      sh      <= '0;
      p       <= 1'b0;
      bit_idx <= '0;
      cnt     <= '0;
      uart_tx <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr.wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            sh      <= mem[rd_ptr];
            p       <= 1'b0;
            cnt     <= BIT_LOAD;
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (cnt == '0) begin
            state   <= DATA;
            bit_idx <= '0;
            cnt     <= BIT_LOAD;
            uart_tx <= sh[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            p       <= p_next;
            sh      <= sh >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              if (PARITY != 0) begin
                state   <= PAR;
                cnt     <= BIT_LOAD;
                uart_tx <= (PARITY == 2) ? p_next : ~p_next;
              end else begin
                state   <= STOP;
                cnt     <= STOP_LOAD;
                uart_tx <= 1'b1;
              end
            end else begin
              cnt     <= BIT_LOAD;
              uart_tx <= sh[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PAR: begin
          if (cnt == '0) begin
            state   <= STOP;
            cnt     <= STOP_LOAD;
            uart_tx <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (pop) begin
              // Next start bit begins on the edge that ends this stop bit.
              sh      <= mem[rd_ptr];
              p       <= 1'b0;
              cnt     <= BIT_LOAD;
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end
endmodule
